// File: rtl/det_sched_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// det_sched block.
package detsched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_WORD_W = 8;
   localparam int DEF_CNT_W  = 4;

   // Index of the first set bit at or after ptr, wrapping at n_req (n_req <= 8).
   function automatic int rr_pick(input logic [7:0] req_vec, input int ptr, input int n_req);
      int   idx;
      logic found;
      rr_pick = 0;
      found   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + i;
         if (idx >= n_req) idx = idx - n_req;
         if (!found && (i < n_req) && req_vec[idx[2:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/det_sched_det.sv
// Moore overlapping 1101 sequence detector; o rises the cycle after the
// final 1 of a match has been sampled.
module seq_det_1101 (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic i,
   output logic o
);

   // prog holds how much of 1101 has been seen: 0 none, 1 "1", 2 "11", 3 "110"
   logic [1:0] prog;
   logic [1:0] prog_nx;

   always_comb begin
      prog_nx = 2'd0;
      case (prog)
         2'd0: prog_nx = i ? 2'd1 : 2'd0;
         2'd1: prog_nx = i ? 2'd2 : 2'd0;
         2'd2: prog_nx = i ? 2'd2 : 2'd3;
         2'd3: prog_nx = i ? 2'd1 : 2'd0;
         default: prog_nx = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         prog <= 2'd0;
         o    <= 1'b0;
      end else begin
         prog <= prog_nx;
         o    <= (prog == 2'd3) && i;
      end
   end

endmodule

// File: rtl/det_sched.sv
// Round-robin scheduler that serialises one requester's word at a time
// through a shared 1101 detector and returns the match count.
import detsched_pkg::*;

module det_sched #(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*WORD_W-1:0] data,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        done,
   output logic [CNT_W-1:0]        match_cnt,
   output logic                    busy
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int BC_W = $clog2(WORD_W);

   state_t            state;
   state_t            state_nx;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   pick;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] pick_word;
   logic [BC_W-1:0]   bitcnt;
   logic [CNT_W-1:0]  acc;
   logic [CNT_W-1:0]  acc_inc;
   logic [7:0]        req_ext;
   logic              det_clr;
   logic              det_i;
   logic              det_o;

   seq_det_1101 u_det (
      .clk (clk),
      .rst (rst),
      .clr (det_clr),
      .i   (det_i),
      .o   (det_o)
   );

   always_comb begin
      req_ext              = '0;
      req_ext[N_REQ-1:0]   = req;
      pick                 = ID_W'(rr_pick(req_ext, int'(rr_ptr), N_REQ));
      pick_word            = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick == ID_W'(k)) pick_word = data[k*WORD_W +: WORD_W];
      end
      acc_inc = (det_o && (acc != '1)) ? acc + CNT_W'(1) : acc;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Clearing the detector on the grant cycle keeps a previous word's tail
   // from producing a match in the first SHIFT cycle.
   always_comb begin
      state_nx = state;
      det_clr  = 1'b0;
      det_i    = 1'b0;
      gnt      = '0;
      done     = '0;
      busy     = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (req != '0) begin
               det_clr  = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            det_i       = shreg[WORD_W-1];
            gnt[owner]  = 1'b1;
            if (bitcnt == BC_W'(WORD_W-1)) state_nx = DRAIN;
         end
         DRAIN: begin
            gnt[owner] = 1'b1;
            state_nx   = DONE;
         end
         DONE: begin
            gnt[owner]  = 1'b1;
            done[owner] = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // match_cnt is loaded on the DRAIN edge so it is already valid while done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= '0;
         rr_ptr    <= '0;
         shreg     <= '0;
         bitcnt    <= '0;
         acc       <= '0;
         match_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req != '0) begin
                  owner  <= pick;
                  shreg  <= pick_word;
                  acc    <= '0;
                  bitcnt <= '0;
               end
            end
            SHIFT: begin
               shreg  <= {shreg[WORD_W-2:0], 1'b0};
               acc    <= acc_inc;
               bitcnt <= bitcnt + BC_W'(1);
            end
            DRAIN: begin
               acc       <= acc_inc;
               match_cnt <= acc_inc;
            end
            DONE: begin
               rr_ptr <= (owner == ID_W'(N_REQ-1)) ? '0 : owner + ID_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_det_sched.sv
// Randomised self-checking bench for det_sched against a behavioural model
// of round-robin arbitration and overlapping 1101 counting.
module tb_det_sched;

   localparam int N = 4;
   localparam int W = 8;
   localparam int C = 4;

   logic         tb_clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N*W-1:0] data;
   logic [N-1:0] gnt;
   logic [N-1:0] done;
   logic [C-1:0] match_cnt;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int mdl_ptr = 0;

   det_sched #(.N_REQ(N), .WORD_W(W), .CNT_W(C)) dut (
      .clk       (tb_clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .done      (done),
      .match_cnt (match_cnt),
      .busy      (busy)
   );

   always #5 tb_clk = ~tb_clk;

   function automatic int count_1101(input logic [W-1:0] w);
      int c = 0;
      for (int i = 0; i <= W - 4; i++)
         if (w[W-1-i -: 4] == 4'b1101) c++;
      if (c > (1 << C) - 1) c = (1 << C) - 1;
      return c;
   endfunction

   function automatic int model_pick(input logic [N-1:0] r, input int ptr);
      for (int i = 0; i < N; i++)
         if (r[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   // Waits from a negedge for the next done pulse (bounded); reports what was seen.
   task automatic observe(output logic [N-1:0] g1, output int dcyc,
                          output logic [N-1:0] dv, output logic [C-1:0] cnt);
      dcyc = -1;
      g1   = '0;
      dv   = '0;
      cnt  = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge tb_clk);
         if (n == 1) g1 = gnt;
         if (done != '0) begin
            dcyc = n;
            dv   = done;
            cnt  = match_cnt;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [N-1:0] g1, dv;
      logic [C-1:0] cnt;
      int           dcyc;
      logic [W-1:0] w0;
      w0   = 8'hDA;
      data = {8'h11, 8'h22, 8'h33, w0};
      req  = 4'b1111;
      for (int k = 0; k < 2; k++) begin
         @(negedge tb_clk);
         checks++;
         if ({gnt, done, match_cnt, busy} !== {4'b0, 4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: gnt=%b done=%b cnt=%0d busy=%b, expected all zero",
                     gnt, done, match_cnt, busy);
         end
      end
      rst = 1'b0;
      mdl_ptr = 0;
      observe(g1, dcyc, dv, cnt);
      checks++;
      if (g1 !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_first_gnt: got %b expected 0001", g1);
      end
      checks++;
      if (dv !== 4'b0001 || dcyc != 10) begin
         errors++;
         $display("[TB] FAIL reset_first_done: got %b at %0d expected 0001 at 10", dv, dcyc);
      end
      checks++;
      if (int'(cnt) != count_1101(w0)) begin
         errors++;
         $display("[TB] FAIL reset_first_cnt: got %0d expected %0d", cnt, count_1101(w0));
      end
      req = '0;
      mdl_ptr = 1;
      @(negedge tb_clk);
   endtask

   task automatic test_patterns();
      logic [W-1:0] pats [4];
      logic [N-1:0] g1, dv;
      logic [C-1:0] cnt;
      int           dcyc;
      pats[0] = 8'b1101_1010;
      pats[1] = 8'b0000_1101;
      pats[2] = 8'hFF;
      pats[3] = 8'h00;
      for (int p = 0; p < 4; p++) begin
         data[0 +: W] = pats[p];
         req = 4'b0001;
         observe(g1, dcyc, dv, cnt);
         checks++;
         if (g1 !== 4'b0001 || dv !== 4'b0001 || dcyc != 10) begin
            errors++;
            $display("[TB] FAIL pattern%0d_timing: gnt=%b done=%b at %0d expected 0001/0001 at 10",
                     p, g1, dv, dcyc);
         end
         checks++;
         if (int'(cnt) != count_1101(pats[p])) begin
            errors++;
            $display("[TB] FAIL pattern%0d_cnt: got %0d expected %0d", p, cnt, count_1101(pats[p]));
         end
         req = '0;
         mdl_ptr = 1;
         @(negedge tb_clk);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g1, dv;
      logic [C-1:0] cnt;
      int           dcyc, exp_id;
      rst = 1'b1;
      @(negedge tb_clk);
      rst = 1'b0;
      mdl_ptr = 0;
      data = {$urandom, $urandom} [N*W-1:0];
      req  = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         exp_id = model_pick(req, mdl_ptr);
         observe(g1, dcyc, dv, cnt);
         checks++;
         if (dv !== 4'(1 << exp_id) || dcyc != (s == 0 ? 10 : 11)) begin
            errors++;
            $display("[TB] FAIL rr%0d_done: got %b at %0d expected %b at %0d",
                     s, dv, dcyc, 4'(1 << exp_id), (s == 0 ? 10 : 11));
         end
         checks++;
         if (int'(cnt) != count_1101(data[exp_id*W +: W])) begin
            errors++;
            $display("[TB] FAIL rr%0d_cnt: got %0d expected %0d",
                     s, cnt, count_1101(data[exp_id*W +: W]));
         end
         mdl_ptr = (exp_id + 1) % N;
      end
      req = '0;
      @(negedge tb_clk);
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g1, dv;
      logic [C-1:0] cnt;
      int           dcyc;
      logic         seen_done;
      data[0 +: W] = 8'b1101_1101;
      req = 4'b0001;
      seen_done = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge tb_clk);
         if (done != '0) seen_done = 1'b1;
      end
      rst = 1'b1;
      @(negedge tb_clk);
      if (done != '0) seen_done = 1'b1;
      checks++;
      if ({gnt, done, match_cnt, busy} !== {4'b0, 4'b0, 4'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: gnt=%b done=%b cnt=%0d busy=%b, expected all zero",
                  gnt, done, match_cnt, busy);
      end
      rst = 1'b0;
      req = '0;
      mdl_ptr = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge tb_clk);
         if (done != '0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_no_done: done pulse seen=%b expected 0", seen_done);
      end
      data = {8'hB6, 8'h0D, 8'hDD, 8'b1000_0000};
      req  = 4'b1111;
      observe(g1, dcyc, dv, cnt);
      checks++;
      if (dv !== 4'b0001 || dcyc != 10 || int'(cnt) != count_1101(8'b1000_0000)) begin
         errors++;
         $display("[TB] FAIL midreset_after: done=%b at %0d cnt=%0d expected 0001 at 10 cnt=%0d",
                  dv, dcyc, cnt, count_1101(8'b1000_0000));
      end
      req = '0;
      mdl_ptr = 1;
      @(negedge tb_clk);
   endtask

   task automatic test_random();
      logic [N-1:0] g1, dv;
      logic [C-1:0] cnt;
      int           dcyc, exp_id;
      for (int it = 0; it < 20; it++) begin
         data = {$urandom, $urandom} [N*W-1:0];
         req  = 4'($urandom_range(1, 15));
         exp_id = model_pick(req, mdl_ptr);
         observe(g1, dcyc, dv, cnt);
         checks++;
         if (g1 !== 4'(1 << exp_id) || dv !== 4'(1 << exp_id) || dcyc != 10) begin
            errors++;
            $display("[TB] FAIL rand%0d_owner: req=%b gnt=%b done=%b at %0d expected %b at 10",
                     it, req, g1, dv, dcyc, 4'(1 << exp_id));
         end
         checks++;
         if (int'(cnt) != count_1101(data[exp_id*W +: W])) begin
            errors++;
            $display("[TB] FAIL rand%0d_cnt: word=%h got %0d expected %0d",
                     it, data[exp_id*W +: W], cnt, count_1101(data[exp_id*W +: W]));
         end
         req = '0;
         mdl_ptr = (exp_id + 1) % N;
         @(negedge tb_clk);
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      data = '0;
      test_reset();
      test_patterns();
      test_round_robin();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
